// File: rtl/b01_te_pkg.sv
// Shared types and constants for the b01 time-expanded pattern checker.
package b01_te_pkg;
  localparam int OBS_W = 11;
  localparam int PAT_W = 13;

  // Feedback taps q[15]^q[13]^q[12]^q[10], shared by pattern LFSR and MISR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int PAT_LINE1_T1  = 12;
  localparam int PAT_LINE2_T1  = 11;
  localparam int PAT_SI_T1     = 10;
  localparam int PAT_SE_T1     = 9;
  localparam int PAT_LINE1_T2  = 8;
  localparam int PAT_LINE2_T2  = 7;
  localparam int PAT_SI_T2     = 6;
  localparam int PAT_SE_T2     = 5;
  localparam int PAT_STATO0    = 4;
  localparam int PAT_STATO2    = 3;
  localparam int PAT_OUTP      = 2;
  localparam int PAT_OVERFLW   = 1;
  localparam int PAT_STATO1    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/b01_te_pattern_checker_if.sv
// Stimulus/response bundle between the checker and the ref/imp miter pair.
interface b01_te_pattern_checker_if
  import b01_te_pkg::*;
#(
  parameter int CNT_W  = 11,
  parameter int LFSR_W = 16
);
  logic              start;
  logic              abort;
  logic [PAT_W-1:0]  pat;
  logic [OBS_W-1:0]  ref_obs;
  logic [OBS_W-1:0]  imp_obs;
  logic              tp_ref;
  logic              tp_imp;
  logic              busy;
  logic              done;
  logic              detected;
  logic [CNT_W-1:0]  first_det_idx;
  logic [CNT_W-1:0]  pat_cnt;
  logic [CNT_W-1:0]  excite_cnt;
  logic [LFSR_W-1:0] signature;

  modport master (
    output start, abort, ref_obs, imp_obs, tp_ref, tp_imp,
    input  pat, busy, done, detected, first_det_idx, pat_cnt, excite_cnt, signature
  );

  modport slave (
    input  start, abort, ref_obs, imp_obs, tp_ref, tp_imp,
    output pat, busy, done, detected, first_det_idx, pat_cnt, excite_cnt, signature
  );
endinterface

// File: rtl/b01_te_lfsr.sv
// Fibonacci shift-left LFSR with optional parallel input, usable as a MISR.
module b01_te_lfsr #(
  parameter int           W       = 16,
  parameter int           IN_W    = 1,
  parameter int           OUT_W   = W,
  parameter logic [W-1:0] TAPS    = 16'hB400,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [W-1:0]     load_val_i,
  input  logic             en_i,
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] q_o
);
  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         fb;

  always_comb begin
    fb  = ^(q_q & TAPS);
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = {q_q[W-2:0], fb} ^ W'(din_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q[OUT_W-1:0];
endmodule

// File: rtl/b01_te_pattern_checker.sv
// Pattern source and response checker wrapped around the b01 ref/imp miter:
// drives one pseudo-random pattern per RUN cycle and scores the responses.
module b01_te_pattern_checker
  import b01_te_pkg::*;
#(
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                MAX_PAT     = 1024,
  parameter int                CNT_W       = 11,
  parameter bit                STOP_ON_DET = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  b01_te_pattern_checker_if.slave   bus
);
  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [LFSR_W-1:0] SEED_G = (SEED == '0) ? LFSR_W'(1) : SEED;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             detected_q;
  logic             pat_vld_q;
  logic [CNT_W-1:0] first_det_q;
  logic [CNT_W-1:0] pat_cnt_q;
  logic [CNT_W-1:0] excite_q;

  logic             start_acc;
  logic             sample;
  logic             mismatch;
  logic             excite;
  logic             last;
  logic [PAT_W-1:0] lfsr_pat;

  assign start_acc = bus.start && (state_q != ST_RUN);
  assign sample    = (state_q == ST_RUN) && !bus.abort;
  assign mismatch  = (bus.ref_obs != bus.imp_obs);
  assign excite    = (bus.tp_ref != bus.tp_imp);
  assign last      = (pat_cnt_q == CNT_W'(MAX_PAT - 1)) || (STOP_ON_DET && mismatch);

  b01_te_lfsr #(
    .W(LFSR_W), .IN_W(1), .OUT_W(PAT_W), .TAPS(LFSR_TAPS), .RST_VAL(SEED_G)
  ) u_pat_lfsr (
    .clk(clock), .rst(reset), .load_i(start_acc), .load_val_i(SEED_G),
    .en_i(sample), .din_i(1'b0), .q_o(lfsr_pat)
  );

  b01_te_lfsr #(
    .W(LFSR_W), .IN_W(OBS_W), .OUT_W(LFSR_W), .TAPS(LFSR_TAPS), .RST_VAL('0)
  ) u_misr (
    .clk(clock), .rst(reset), .load_i(start_acc), .load_val_i('0),
    .en_i(sample), .din_i(bus.ref_obs), .q_o(bus.signature)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      detected_q  <= 1'b0;
      pat_vld_q   <= 1'b0;
      first_det_q <= '0;
      pat_cnt_q   <= '0;
      excite_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            detected_q  <= 1'b0;
            pat_vld_q   <= 1'b1;
            first_det_q <= '0;
            pat_cnt_q   <= '0;
            excite_q    <= '0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pat_cnt_q <= pat_cnt_q + 1'b1;
            if (excite && (excite_q != '1)) excite_q <= excite_q + 1'b1;
            if (mismatch && !detected_q) begin
              detected_q  <= 1'b1;
              first_det_q <= pat_cnt_q;
            end
            if (last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // pat reads as 0 until the first start after reset, then tracks the LFSR
  assign bus.pat           = pat_vld_q ? lfsr_pat : '0;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.detected      = detected_q;
  assign bus.first_det_idx = first_det_q;
  assign bus.pat_cnt       = pat_cnt_q;
  assign bus.excite_cnt    = excite_q;
endmodule

// File: doc/b01_te_pattern_checker.md
Name: b01_te_pattern_checker

Overview:
- Sequential pattern source and response checker that sits directly upstream and downstream of the b01 two-frame time-expanded fault miter (the ref/imp pair).
- Generates pseudo-random two-frame stimulus, drives the same vector into both the ref and the imp instance, and samples their observable outputs.
- Compares the two instances, counts fault-site excitations (tp_ref != tp_imp) and detections (any output mismatch), and compacts the ref responses into a MISR signature.
- Lets fault-simulation runs execute per injected fault without a testbench in the loop.

Parameters:
- LFSR_W, 16, width of the pattern LFSR and of the MISR.
- SEED, 16'hACE1, LFSR value loaded on start. A value of 0 is replaced by 16'h0001.
- MAX_PAT, 1024, number of patterns per run (1..2**CNT_W-1).
- CNT_W, 11, width of the pattern and excitation counters.
- STOP_ON_DET, 1, 1 = end the run on the first detection; 0 = run all MAX_PAT patterns.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that starts a run. Accepted only in IDLE or DONE.
- abort  in  1  ends a run in progress; the FSM goes to DONE.
- pat  out  13  stimulus vector, mapped as follows:
  - [12:9] = line1_t1, line2_t1, test_si_t1, test_se_t1
  - [8:5] = line1_t2, line2_t2, test_si_t2, test_se_t2
  - [4:0] = ppi_stato_reg_0_, ppi_stato_reg_2_, ppi_outp_reg, ppi_overflw_reg, ppi_stato_reg_1_ (t1 frame)
- ref_obs  in  11  ref instance outputs: outp_t1, overflw_t1, test_so_t1, outp_t2, overflw_t2, test_so_t2, ppo_stato_reg_0_/2_, ppo_outp_reg, ppo_overflw_reg, ppo_stato_reg_1_ (t2 frame).
- imp_obs  in  11  imp instance outputs, same order as ref_obs.
- tp_ref  in  1  fault-site value, good machine.
- tp_imp  in  1  fault-site value, faulty machine.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- detected  out  1  sticky; set on the first mismatch of a run.
- first_det_idx  out  CNT_W  index of the first detecting pattern.
- pat_cnt  out  CNT_W  number of patterns evaluated in the current or last run.
- excite_cnt  out  CNT_W  number of patterns with tp_ref != tp_imp. Saturates at all-ones.
- signature  out  LFSR_W  MISR of ref_obs over the evaluated patterns.

Behaviour:
- Reset values: FSM = IDLE, pat = 0, lfsr = SEED (0 guarded), busy = 0, done = 0, detected = 0, first_det_idx = 0, pat_cnt = 0, excite_cnt = 0, signature = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(pat_cnt reaches MAX_PAT) | abort | (STOP_ON_DET & mismatch)--> DONE.
  - DONE --start--> RUN.
  - start while in RUN is ignored.
- On start (entering RUN):
  - lfsr <= SEED and pat <= SEED[12:0], so the first pattern with the default seed is 13'h0CE1.
  - pat_cnt, excite_cnt, detected, first_det_idx and signature are cleared.
- LFSR: Fibonacci, shift left, feedback bit = q[15]^q[13]^q[12]^q[10] into q[0]. The lfsr never holds 0.
- Timing in RUN:
  - The miter is purely combinational. Pattern k is held on pat for exactly one cycle.
  - ref_obs, imp_obs, tp_ref and tp_imp are sampled at the end of that same cycle.
  - On the same edge: pat_cnt increments and pat <= next lfsr[12:0].
  - Latency from start to the first sample is 1 cycle. A full run takes MAX_PAT cycles in RUN.
- Mismatch = (ref_obs != imp_obs).
  - The first mismatch sets detected and first_det_idx = pat_cnt, the value before the increment (0-based).
  - Later mismatches do not change first_det_idx.
- Excitation: excite_cnt increments when tp_ref != tp_imp and saturates at all-ones.
- MISR update each RUN sample: signature <= {signature[14:0], fb} ^ {5'b0, ref_obs}, using the same feedback taps as the LFSR.
- Run end:
  - The sample on the terminal cycle is counted before entering DONE.
  - A STOP_ON_DET run that first detects at index i ends with pat_cnt = i+1.
- abort in RUN:
  - The current cycle's sample is discarded and no counter updates.
  - Next state is DONE; detected and other results stay as accumulated.
- abort and start together: abort has priority in RUN; start wins in IDLE/DONE.
- pat holds its last value outside RUN.
- reset at any time, including mid-RUN, returns all state to the reset values on the next edge.

Decomposition:
- Shared package b01_te_pkg holds:
  - the FSM state enum
  - the pattern bit-index constants
  - OBS_W = 11 and PAT_W = 13
  - the LFSR/MISR tap constant
- One natural sub-module, b01_te_lfsr (width and taps parameterised). It is instantiated twice: once as the pattern LFSR and once as the MISR with parallel input.

Test Plan:
- Reset then start, with imp_obs tied to ref_obs and tp_imp = tp_ref, MAX_PAT = 1024 -> first pat = 13'h0CE1; busy for 1024 cycles; done = 1, detected = 0, pat_cnt = 1024, excite_cnt = 0.
- imp_obs[0] inverted only on pattern index 5, STOP_ON_DET = 1 -> detected = 1, first_det_idx = 5, pat_cnt = 6, done on the following cycle.
- Same stimulus with STOP_ON_DET = 0 and tp_imp != tp_ref on patterns 2, 3 and 5 -> first_det_idx = 5, pat_cnt = 1024, excite_cnt = 3.
- abort asserted on the 10th RUN cycle -> pat_cnt = 9 and done = 1. A second start then repeats the identical pat sequence and a fault-free signature equal to the reference model's.
- reset asserted mid-RUN at pat_cnt = 300 -> next cycle all outputs are at reset values. start during RUN is shown to be ignored (pat_cnt continues).
- SEED = 0 -> lfsr loads 16'h0001 and the first pat = 13'h0001; the lfsr never reaches 0 over 1024 patterns.
